// File: rtl/pll_freq_monitor.sv
// pll_freq_monitor: measures a PLL-derived clock against clkin by counting
// synchronized rising edges of clk_mon over a fixed gate window, then
// classifies each window and tracks lock / fault status.
//
// Ports:
//   clkin        system clock, rising edge
//   rst          asynchronous active-high reset
//   clk_mon      monitored clock, sampled as asynchronous data
//   enable       1 = monitor runs, 0 = idle with window counters cleared
//   count_out    edge count of the last completed window
//   count_valid  one-cycle pulse when count_out updates
//   locked       LOCK_WINDOWS consecutive good windows seen
//   fault        last completed window out of tolerance
//   fault_cnt    bad windows since reset, saturating at 255
//
// Build option: define PLL_MON_STICKY_FAULT_EN to make FAULT sticky until
// enable drops or rst is asserted.
module pll_freq_monitor #(
  parameter int unsigned GATE_CYCLES  = 27000,
  parameter int unsigned EXP_COUNT    = 1000,
  parameter int unsigned TOL          = 2,
  parameter int unsigned LOCK_WINDOWS = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             clk_mon,
  input  logic             enable,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             locked,
  output logic             fault,
  output logic [7:0]       fault_cnt
);

  localparam int unsigned GATE_W   = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned GOOD_W   = $clog2(LOCK_WINDOWS + 1);
  localparam int unsigned CMP_W    = CNT_W + 1;
  localparam int unsigned LO_BOUND = (EXP_COUNT > TOL) ? EXP_COUNT - TOL : 0;
  localparam int unsigned HI_BOUND = EXP_COUNT + TOL;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  // Elaboration-time parameter sanity checks
  if (GATE_CYCLES < 2) begin : g_chk_gate
    $error("pll_freq_monitor: GATE_CYCLES must be >= 2");
  end
  if ((64'(EXP_COUNT) + 64'(TOL)) >= (64'd1 << CNT_W)) begin : g_chk_range
    $error("pll_freq_monitor: EXP_COUNT+TOL must fit in CNT_W bits");
  end
  if (LOCK_WINDOWS < 1) begin : g_chk_lock
    $error("pll_freq_monitor: LOCK_WINDOWS must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_LOCKED, S_FAULT} state_t;

  logic              mon_s1, mon_s2, mon_prev;
  logic              rise_c;
  logic [GATE_W-1:0] gate;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  win_cnt_c;
  logic              win_end_c;
  logic              win_good_c;
  state_t            state, state_nxt;
  logic [GOOD_W-1:0] good_cnt, good_cnt_nxt;
  logic [7:0]        fault_cnt_nxt;

  // Two-flop synchronizer plus a history flop for rise detection
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      mon_s1   <= 1'b0;
      mon_s2   <= 1'b0;
      mon_prev <= 1'b0;
    end else begin
      mon_s1   <= clk_mon;
      mon_s2   <= mon_s1;
      mon_prev <= mon_s2;
    end
  end

  assign rise_c    = mon_s2 & ~mon_prev;
  assign win_end_c = enable && (gate == GATE_LAST);

  // Window total including a rise detected on this cycle (saturating)
  assign win_cnt_c = (rise_c && (edge_cnt != '1)) ? edge_cnt + CNT_W'(1) : edge_cnt;

  assign win_good_c = (CMP_W'(win_cnt_c) >= CMP_W'(LO_BOUND)) &&
                      (CMP_W'(win_cnt_c) <= CMP_W'(HI_BOUND));

  // Gate counter, edge counter and window latch
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      gate        <= '0;
      edge_cnt    <= '0;
      count_out   <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= win_end_c;
      if (!enable) begin
        gate     <= '0;
        edge_cnt <= '0;
      end else if (gate == GATE_LAST) begin
        gate      <= '0;
        edge_cnt  <= '0;
        count_out <= win_cnt_c;
      end else begin
        gate     <= gate + GATE_W'(1);
        edge_cnt <= win_cnt_c;
      end
    end
  end

  // Lock/fault FSM: next state, good-window run length and fault tally
  always_comb begin
    state_nxt     = state;
    good_cnt_nxt  = good_cnt;
    fault_cnt_nxt = fault_cnt;

    if (win_end_c && !win_good_c && (fault_cnt != 8'hFF)) begin
      fault_cnt_nxt = fault_cnt + 8'd1;
    end

    if (!enable) begin
      state_nxt    = S_IDLE;
      good_cnt_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt    = S_ACQUIRE;
          good_cnt_nxt = '0;
        end
        S_ACQUIRE: begin
          if (win_end_c) begin
            if (win_good_c) begin
              good_cnt_nxt = good_cnt + GOOD_W'(1);
              if ((32'(good_cnt) + 32'd1) >= LOCK_WINDOWS) begin
                state_nxt = S_LOCKED;
              end
            end else begin
              good_cnt_nxt = '0;
              state_nxt    = S_FAULT;
            end
          end
        end
        S_LOCKED: begin
          if (win_end_c && !win_good_c) begin
            good_cnt_nxt = '0;
            state_nxt    = S_FAULT;
          end
        end
        S_FAULT: begin
`ifdef PLL_MON_STICKY_FAULT_EN
          state_nxt = S_FAULT;
`else
          // The recovering window is the first of the new good run
          if (win_end_c && win_good_c) begin
            good_cnt_nxt = GOOD_W'(1);
            state_nxt    = (LOCK_WINDOWS <= 1) ? S_LOCKED : S_ACQUIRE;
          end
`endif
        end
        default: begin
          state_nxt    = S_IDLE;
          good_cnt_nxt = '0;
        end
      endcase
    end
  end

  // FSM state and registered status outputs
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      good_cnt  <= '0;
      locked    <= 1'b0;
      fault     <= 1'b0;
      fault_cnt <= '0;
    end else begin
      state     <= state_nxt;
      good_cnt  <= good_cnt_nxt;
      locked    <= (state_nxt == S_LOCKED);
      fault     <= (state_nxt == S_FAULT);
      fault_cnt <= fault_cnt_nxt;
    end
  end

endmodule

// File: doc/pll_freq_monitor.md
Name: pll_freq_monitor

Overview:
- Checks the frequency of a PLL-derived clock (e.g. the 1 MHz divided output) against the 27 MHz input clock.
- Samples the monitored clock as an asynchronous data signal and counts its rising edges over a fixed gate window of clkin cycles.
- Compares each window count to an expected range and drives lock and fault status.
- Sits beside the PLL wrapper and feeds status LEDs and the system reset sequencer.

Parameters:
GATE_CYCLES, 27000, gate window length in clkin cycles (1 ms at 27 MHz)
EXP_COUNT, 1000, expected rising edges per window
TOL, 2, allowed deviation; a window is good when |count - EXP_COUNT| <= TOL
LOCK_WINDOWS, 4, consecutive good windows required to declare lock
CNT_W, 16, width of the edge counter and count_out

Ports:
clkin  input  1  system clock (27 MHz), rising-edge
rst  input  1  asynchronous active-high reset
clk_mon  input  1  monitored clock, asynchronous to clkin; treated as data
enable  input  1  1 = monitor runs; 0 = idle, counters cleared
count_out  output  CNT_W  edge count of the last completed window
count_valid  output  1  one-cycle pulse when count_out updates
locked  output  1  frequency within tolerance for LOCK_WINDOWS windows
fault  output  1  last completed window was out of tolerance (see FSM)
fault_cnt  output  8  number of bad windows since reset, saturating at 255

Behaviour:
- Reset: clkin is the only clock. Reset is asynchronous and active-high. All flops clear, including the synchronizer. Outputs reset to: count_out=0, count_valid=0, locked=0, fault=0, fault_cnt=0. FSM goes to IDLE.
- Input path: clk_mon passes through a 2-flop synchronizer, then a third flop for edge detection. A rise is detected when sync=1 and prev=0. Detection latency is 3 clkin cycles from the clk_mon edge.
- Gate counter: runs 0..GATE_CYCLES-1 while enable=1 and wraps with no dead cycle. It is held at 0 while enable=0, and restarts at 0 on the first cycle enable=1.
- Edge counter:
  - Increments by 1 on each detected rise and saturates at 2^CNT_W-1.
  - On the last gate cycle (gate=GATE_CYCLES-1), the final value including any rise in that cycle is latched into count_out. The edge counter then reloads to 0, or to 1 if a rise is detected in that same cycle? No: a rise in the last cycle belongs to the ending window, and a rise in the first cycle of the next window counts toward the new window.
- count_valid: asserted for exactly the one cycle after the latch. count_out is stable until the next latch.
- Window classification: good = (count_out >= EXP_COUNT-TOL) and (count_out <= EXP_COUNT+TOL). Use CNT_W+1-bit signed-safe compare; the lower bound clamps at 0.
- FSM, evaluated on each window end:
  - IDLE: enable=0; locked=0, fault=0, good-window counter cleared. enable=1 -> ACQUIRE.
  - ACQUIRE: good window -> good_cnt++. When good_cnt reaches LOCK_WINDOWS -> LOCKED and locked=1. Bad window -> good_cnt=0, fault=1, go to FAULT.
  - LOCKED: good window -> stay. Bad window -> locked=0, fault=1, go to FAULT.
  - FAULT (non-sticky build): good window -> fault=0, good_cnt=1, go to ACQUIRE. Bad window -> stay.
  - Any state with enable=0 -> IDLE next cycle. count_out and fault_cnt are retained.
- fault_cnt: increments on every bad window, in any state, and saturates at 255.
- locked and fault update in the same cycle count_valid asserts.
- LOCK_WINDOWS=1: the first good window locks.
- Stopped clock: the window count is 0, which is bad unless EXP_COUNT<=TOL.
- Mid-operation reset: asynchronous; everything is cleared immediately and the partial window is discarded.
- Requirements: GATE_CYCLES >= 2 and EXP_COUNT+TOL < 2^CNT_W. Both are checked by elaboration assertions.

Optional Feature:
- Macro: PLL_MON_STICKY_FAULT_EN.
- Defined: FAULT is sticky. fault stays 1 and the FSM stays in FAULT regardless of later good windows. Only enable=0 (to IDLE) or rst clears it. count_out, count_valid and fault_cnt keep updating.
- Undefined: non-sticky recovery as described under Behaviour.

Test Plan:
- Reset: rst pulse, enable=0 -> all outputs 0. enable=1, clk_mon at 1 MHz (period 1000 ns, clkin 37.037 ns) -> count_valid pulses every 27000 cycles with count_out within 999..1001. locked=1 at the 4th count_valid; fault stays 0.
- Frequency error: switch clk_mon to 1.1 MHz while locked -> next full window has count_out≈1100; locked=0, fault=1, fault_cnt=1. Restore 1 MHz -> non-sticky build: fault=0 after the next good window, locked=1 four good windows later.
- Stopped clock: hold clk_mon=0 while locked -> count_out=0, fault=1; fault_cnt increments every window.
- Boundary edge: force a detected rise exactly on gate cycle 26999 -> counted in the ending window (count_out=EXP_COUNT exactly with a crafted stimulus). A rise on cycle 0 counts in the next window.
- Enable/reset mid-window: drop enable at gate 13000 -> IDLE, locked=0, no count_valid. Re-enable -> first count_valid 27000 cycles later. Assert rst mid-window -> outputs 0 immediately.
- Sticky build (PLL_MON_STICKY_FAULT_EN): bad window then 10 good windows -> fault remains 1, locked=0. enable low for 1 cycle -> fault=0.
